instr_dispatcher: RTL and testbench

In-order dispatch stage between decode and the ALU, load and store reservation buffers; it is the transmitting end of the `*_Instr / *_InstrNO / *_DR / *buffer_ready` handshake that those buffers receive.
- Takes one 8-instruction decode bundle at a time and classifies each word by opcode.
- Tags each word with a monotonically increasing instruction number.
- Sends at most one instruction per cycle to the matching buffer, stalling while that buffer is not ready.

---
 rtl/dispatch_pkg.sv | 25 ++
 rtl/instr_dispatcher_classifier.sv | 20 ++
 rtl/instr_dispatcher.sv | 161 ++++++++++++++++
 tb/tb_instr_dispatcher.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared definitions for the instruction dispatch stage.
//   - opcode constants used to classify instruction words
//   - instruction class enum (ALU / load / store)
//   - dispatcher FSM state enum
//   - default bundle width and tag width
package dispatch_pkg;

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B;

    localparam int unsigned DEFAULT_SLOTS = 8;
    localparam int unsigned DEFAULT_TAG_W = 32;

    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_LD  = 2'd1,
        CLS_STR = 2'd2
    } instr_class_t;

    typedef enum logic {
        IDLE = 1'b0,
        DISP = 1'b1
    } disp_state_t;

endpackage

// File: rtl/instr_dispatcher_classifier.sv
// instr_classifier: purely combinational opcode decode.
// Ports:
//   instr       in  32 : instruction word
//   instr_class out    : CLS_LD for lw, CLS_STR for sw, CLS_ALU otherwise
module instr_classifier
    import dispatch_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t instr_class
);

    always_comb begin
        unique case (instr[31:26])
            OP_LW:   instr_class = CLS_LD;
            OP_SW:   instr_class = CLS_STR;
            default: instr_class = CLS_ALU;
        endcase
    end

endmodule

// File: rtl/instr_dispatcher.sv
// instr_dispatcher: in-order dispatch of one decode bundle at a time to the
// ALU, load and store reservation buffers, one instruction per cycle, each
// tagged with a monotonically increasing (wrapping) instruction number.
//
// Ports:
//   clk, rst (async, active-high)
//   bundle_valid / bundle_instr / bundle_ack : decode bundle handshake
//   flush                                     : discard held bundle
//   ALUbuffer_ready, Ldbuffer_ready, Strbuffer_ready : buffer can accept
//   {ALU,Ld,Str}_Instr / _InstrNO / _DR      : per-buffer word, tag, strobe
//   busy                                      : a bundle is held
//
// Optional feature macro: DISPATCH_SKIP_NOP_EN -- all-zero slots are
// skipped (one cycle, no DR, no tag consumed).
module instr_dispatcher
    import dispatch_pkg::*;
#(
    parameter int unsigned SLOTS = DEFAULT_SLOTS,
    parameter int unsigned TAG_W = DEFAULT_TAG_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bundle_valid,
    input  logic [SLOTS*32-1:0] bundle_instr,
    output logic                bundle_ack,
    input  logic                flush,
    input  logic                ALUbuffer_ready,
    input  logic                Ldbuffer_ready,
    input  logic                Strbuffer_ready,
    output logic [31:0]         ALU_Instr,
    output logic [31:0]         Ld_Instr,
    output logic [31:0]         Str_Instr,
    output logic [TAG_W-1:0]    ALU_InstrNO,
    output logic [TAG_W-1:0]    Ld_InstrNO,
    output logic [TAG_W-1:0]    Str_InstrNO,
    output logic                ALU_DR,
    output logic                Ld_DR,
    output logic                Str_DR,
    output logic                busy
);

    localparam int unsigned IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);

    disp_state_t      state_q;
    logic [IDX_W-1:0] slot_idx_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      bundle_q [SLOTS];

    logic [31:0]  cur_instr;
    instr_class_t cur_class;
    logic         in_disp;
    logic         skip;
    logic         target_ready;
    logic         transfer;
    logic         advance;

    assign in_disp   = (state_q == DISP);
    assign cur_instr = bundle_q[slot_idx_q];

    instr_classifier u_classifier (
        .instr       (cur_instr),
        .instr_class (cur_class)
    );

`ifdef DISPATCH_SKIP_NOP_EN
    assign skip = in_disp && (cur_instr == '0);
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        unique case (cur_class)
            CLS_LD:  target_ready = Ldbuffer_ready;
            CLS_STR: target_ready = Strbuffer_ready;
            default: target_ready = ALUbuffer_ready;
        endcase
    end

    // DR depends only on registered state, flush and ready -- never on
    // bundle_instr -- so the buffers see no combinational path from decode.
    assign transfer   = in_disp && !flush && !skip && target_ready;
    assign advance    = in_disp && !flush && (skip || target_ready);
    assign bundle_ack = !in_disp && bundle_valid && !flush;
    assign busy       = in_disp;

    // Word and tag are presented to the target whenever a slot is current,
    // regardless of ready; every non-target output stays at zero.
    always_comb begin
        ALU_Instr   = '0;
        Ld_Instr    = '0;
        Str_Instr   = '0;
        ALU_InstrNO = '0;
        Ld_InstrNO  = '0;
        Str_InstrNO = '0;
        ALU_DR      = 1'b0;
        Ld_DR       = 1'b0;
        Str_DR      = 1'b0;
        if (in_disp && !skip) begin
            unique case (cur_class)
                CLS_LD: begin
                    Ld_Instr   = cur_instr;
                    Ld_InstrNO = tag_q;
                    Ld_DR      = transfer;
                end
                CLS_STR: begin
                    Str_Instr   = cur_instr;
                    Str_InstrNO = tag_q;
                    Str_DR      = transfer;
                end
                default: begin
                    ALU_Instr   = cur_instr;
                    ALU_InstrNO = tag_q;
                    ALU_DR      = transfer;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            slot_idx_q <= '0;
            tag_q      <= '0;
            for (int unsigned k = 0; k < SLOTS; k++) begin
                bundle_q[k] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bundle_ack) begin
                        for (int unsigned k = 0; k < SLOTS; k++) begin
                            bundle_q[k] <= bundle_instr[32*k +: 32];
                        end
                        slot_idx_q <= '0;
                        state_q    <= DISP;
                    end
                end
                DISP: begin
                    // Flush keeps the tag counter so tags stay unique across redirects.
                    if (flush) begin
                        slot_idx_q <= '0;
                        state_q    <= IDLE;
                    end else if (advance) begin
                        if (transfer) begin
                            tag_q <= tag_q + TAG_W'(1);
                        end
                        if (slot_idx_q == LAST_IDX) begin
                            slot_idx_q <= '0;
                            state_q    <= IDLE;
                        end else begin
                            slot_idx_q <= slot_idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_dispatcher.sv
// tb_instr_dispatcher: directed + randomized self-checking bench.
// The reference model is a queue of pending words plus an integer tag count.
// A second instance with TAG_W=4 shares all inputs so tag wrap-around
// (15 -> 0 without a gap) is exercised many times.
module tb_instr_dispatcher;

    localparam int SLOTS = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               bundle_valid;
    logic [SLOTS*32-1:0] bundle_instr;
    logic               flush;
    logic               alu_rdy, ld_rdy, str_rdy;

    logic        bundle_ack, busy;
    logic [31:0] alu_i, ld_i, str_i, alu_n, ld_n, str_n;
    logic        alu_dr, ld_dr, str_dr;

    logic        s_ack, s_busy;
    logic [31:0] s_alu_i, s_ld_i, s_str_i;
    logic [3:0]  s_alu_n, s_ld_n, s_str_n;
    logic        s_alu_dr, s_ld_dr, s_str_dr;

    int tests = 0;
    int fails = 0;

    logic [31:0]     q_word [$];
    longint unsigned tag_cnt;

    always #5 clk = ~clk;

    instr_dispatcher #(.SLOTS(SLOTS), .TAG_W(32)) dut (
        .clk(clk), .rst(rst), .bundle_valid(bundle_valid), .bundle_instr(bundle_instr),
        .bundle_ack(bundle_ack), .flush(flush),
        .ALUbuffer_ready(alu_rdy), .Ldbuffer_ready(ld_rdy), .Strbuffer_ready(str_rdy),
        .ALU_Instr(alu_i), .Ld_Instr(ld_i), .Str_Instr(str_i),
        .ALU_InstrNO(alu_n), .Ld_InstrNO(ld_n), .Str_InstrNO(str_n),
        .ALU_DR(alu_dr), .Ld_DR(ld_dr), .Str_DR(str_dr), .busy(busy)
    );

    instr_dispatcher #(.SLOTS(SLOTS), .TAG_W(4)) dut_small (
        .clk(clk), .rst(rst), .bundle_valid(bundle_valid), .bundle_instr(bundle_instr),
        .bundle_ack(s_ack), .flush(flush),
        .ALUbuffer_ready(alu_rdy), .Ldbuffer_ready(ld_rdy), .Strbuffer_ready(str_rdy),
        .ALU_Instr(s_alu_i), .Ld_Instr(s_ld_i), .Str_Instr(s_str_i),
        .ALU_InstrNO(s_alu_n), .Ld_InstrNO(s_ld_n), .Str_InstrNO(s_str_n),
        .ALU_DR(s_alu_dr), .Ld_DR(s_ld_dr), .Str_DR(s_str_dr), .busy(s_busy)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // 0 = ALU, 1 = load, 2 = store
    function automatic int cls_of(input logic [31:0] w);
        if (w[31:26] == 6'h23) return 1;
        if (w[31:26] == 6'h2B) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] mk_word(input int kind);
        logic [5:0] op;
        logic [31:0] r;
        r = $urandom;
        if (kind == 1) op = 6'h23;
        else if (kind == 2) op = 6'h2B;
        else begin
            op = 6'($urandom_range(0, 63));
            if (op == 6'h23 || op == 6'h2B) op = 6'h00;
        end
        return {op, r[25:0]};
    endfunction

    function automatic logic [SLOTS*32-1:0] pack(input logic [31:0] w [SLOTS]);
        logic [SLOTS*32-1:0] b;
        for (int k = 0; k < SLOTS; k++) b[32*k +: 32] = w[k];
        return b;
    endfunction

    task automatic chk_zero(input string name);
        chk({name, ".ALU_DR"}, {31'b0, alu_dr}, 32'd0);
        chk({name, ".Ld_DR"},  {31'b0, ld_dr},  32'd0);
        chk({name, ".Str_DR"}, {31'b0, str_dr}, 32'd0);
        chk({name, ".ack"},    {31'b0, bundle_ack}, 32'd0);
        chk({name, ".busy"},   {31'b0, busy}, 32'd0);
        chk({name, ".ALU_Instr"}, alu_i, 32'd0);
        chk({name, ".Ld_InstrNO"}, ld_n, 32'd0);
        chk({name, ".small.Str_DR"}, {31'b0, s_str_dr}, 32'd0);
    endtask

    // One clock cycle: drive, check at negedge against the model, advance model.
    task automatic step(input string name, input logic v, input logic [SLOTS*32-1:0] b,
                        input logic f, input logic ra, input logic rl, input logic rs);
        logic pend, skip_e, show, rdy, xfer, ack_e;
        int c;
        logic [31:0] w, t;
        bundle_valid = v; bundle_instr = b; flush = f;
        alu_rdy = ra; ld_rdy = rl; str_rdy = rs;
        @(negedge clk);
        pend  = (q_word.size() != 0);
        ack_e = !pend && v && !f;
        w     = pend ? q_word[0] : 32'd0;
`ifdef DISPATCH_SKIP_NOP_EN
        skip_e = pend && (w == 32'd0);
`else
        skip_e = 1'b0;
`endif
        c    = cls_of(w);
        show = pend && !skip_e;
        rdy  = (c == 1) ? rl : (c == 2) ? rs : ra;
        xfer = show && !f && rdy;
        t    = tag_cnt[31:0];
        chk({name, ".ack"},  {31'b0, bundle_ack}, {31'b0, ack_e});
        chk({name, ".busy"}, {31'b0, busy}, {31'b0, pend});
        chk({name, ".ALU_DR"}, {31'b0, alu_dr}, {31'b0, xfer && c == 0});
        chk({name, ".Ld_DR"},  {31'b0, ld_dr},  {31'b0, xfer && c == 1});
        chk({name, ".Str_DR"}, {31'b0, str_dr}, {31'b0, xfer && c == 2});
        chk({name, ".ALU_Instr"}, alu_i, (show && c == 0) ? w : 32'd0);
        chk({name, ".Ld_Instr"},  ld_i,  (show && c == 1) ? w : 32'd0);
        chk({name, ".Str_Instr"}, str_i, (show && c == 2) ? w : 32'd0);
        chk({name, ".ALU_InstrNO"}, alu_n, (show && c == 0) ? t : 32'd0);
        chk({name, ".Ld_InstrNO"},  ld_n,  (show && c == 1) ? t : 32'd0);
        chk({name, ".Str_InstrNO"}, str_n, (show && c == 2) ? t : 32'd0);
        chk({name, ".small.DR"}, {29'b0, s_alu_dr, s_ld_dr, s_str_dr},
            {29'b0, xfer && c == 0, xfer && c == 1, xfer && c == 2});
        chk({name, ".small.InstrNO"}, {20'b0, s_alu_n, s_ld_n, s_str_n},
            {20'b0, (show && c == 0) ? t[3:0] : 4'd0, (show && c == 1) ? t[3:0] : 4'd0,
             (show && c == 2) ? t[3:0] : 4'd0});
        @(posedge clk);
        if (pend) begin
            if (f) q_word.delete();
            else if (skip_e || xfer) begin
                void'(q_word.pop_front());
                if (xfer) tag_cnt++;
            end
        end else if (ack_e) begin
            for (int k = 0; k < SLOTS; k++) q_word.push_back(b[32*k +: 32]);
        end
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && q_word.size() != 0; i++)
            step(name, 1'b0, {8{$urandom}}, 1'b0, 1'b1, 1'b1, 1'b1);
        chk({name, ".drained"}, q_word.size(), 32'd0);
    endtask

    task automatic model_reset();
        q_word.delete();
        tag_cnt = 0;
    endtask

    initial begin
        logic [31:0] w [SLOTS];
        logic [SLOTS*32-1:0] b;

        rst = 1'b1; bundle_valid = 1'b0; bundle_instr = '0; flush = 1'b0;
        alu_rdy = 1'b0; ld_rdy = 1'b0; str_rdy = 1'b0;
        model_reset();
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        step("post_reset", 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);

        // 2 lw, 2 sw, 4 alu with all buffers ready
        w[0] = mk_word(1); w[1] = mk_word(1); w[2] = mk_word(2); w[3] = mk_word(2);
        for (int k = 4; k < SLOTS; k++) w[k] = mk_word(0);
        b = pack(w);
        step("seq.ack", 1'b1, b, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < SLOTS; k++) step("seq", 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        step("seq.idle", 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("seq.tag", tag_cnt[31:0], 32'd8);

        // load buffer stalls three cycles on slot 0
        model_reset();
        rst = 1'b1; #1; rst = 1'b0;
        w[0] = mk_word(1); w[1] = mk_word(0);
        for (int k = 2; k < SLOTS; k++) w[k] = mk_word($urandom_range(0, 2));
        b = pack(w);
        step("stall.ack", 1'b1, b, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step("stall.hold", 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        drain("stall.go");

        // flush while slot 4 is current; tags continue afterwards
        w[4] = mk_word(0);
        b = pack(w);
        step("flush.ack", 1'b1, b, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) step("flush.pre", 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        step("flush.hit", 1'b1, b, 1'b1, 1'b1, 1'b1, 1'b1);
        step("flush.idle", 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        step("flush.next", 1'b1, pack(w), 1'b0, 1'b1, 1'b1, 1'b1);
        drain("flush.next");

        // zero word in slot 3
        for (int k = 0; k < SLOTS; k++) w[k] = mk_word(0);
        w[3] = 32'd0;
        step("nop.ack", 1'b1, pack(w), 1'b0, 1'b1, 1'b1, 1'b1);
        drain("nop");

        // asynchronous reset in the middle of a bundle, at slot 5
        step("rst.ack", 1'b1, pack(w), 1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) step("rst.pre", 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        #2 rst = 1'b1;
        #1 chk_zero("rst.mid");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        step("rst.next", 1'b1, pack(w), 1'b0, 1'b1, 1'b1, 1'b1);
        drain("rst.next");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < SLOTS; k++)
                w[k] = ($urandom_range(0, 15) == 0) ? 32'd0 : mk_word($urandom_range(0, 2));
            step("rand", 1'($urandom_range(0, 1)), pack(w), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0));
        end
        drain("rand.end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
